// File: rtl/t05_sram_bus_responder.sv
// SRAM bus responder: word memory behind a busy_o handshake; completion is the busy_o falling edge.
// Optional out-of-window checking (DEADBEEF reads, sticky oob_err) when T05_SRAM_RESP_OOB_EN is defined.
module t05_sram_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wr_en,
  input  logic        r_en,
  input  logic [3:0]  select,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic        busy_o,
  output logic [31:0] data_o,
  output logic        oob_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_lat_cnt;
  logic        r_req, r_req_wr;
  logic [31:0] r_req_addr, r_req_data;
  logic [3:0]  r_req_sel;
  logic        r_op_wr;
  logic [31:0] r_op_addr, r_op_data;
  logic [3:0]  r_op_sel;
  logic [31:0] r_data_o;
  logic        r_oob;
  logic [31:0] mem [DEPTH_WORDS];

  logic          w_cap, w_accept, w_done, w_oob, w_unused_bits;
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: if (r_req) begin
        w_next   = BUSY;
        w_accept = 1'b1;
      end
      BUSY: if (r_lat_cnt == 4'd0) begin
        w_next = IDLE;
        w_done = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // Requests are sampled while idle and on the completing edge, so a held request restarts at once.
  assign w_cap = (r_state == IDLE) | w_done;
  assign w_off = r_op_addr - BASE_ADDR;
  assign w_idx = w_off[AW+1:2];

`ifdef T05_SRAM_RESP_OOB_EN
  assign w_oob         = (w_off[31:2] >= 30'(DEPTH_WORDS));
  assign w_unused_bits = ^w_off[1:0];
`else
  assign w_oob         = 1'b0;
  assign w_unused_bits = ^{w_off[31:AW+2], w_off[1:0]};
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_lat_cnt  <= 4'd0;
      r_req      <= 1'b0;
      r_req_wr   <= 1'b0;
      r_req_addr <= 32'd0;
      r_req_data <= 32'd0;
      r_req_sel  <= 4'd0;
      r_op_wr    <= 1'b0;
      r_op_addr  <= 32'd0;
      r_op_data  <= 32'd0;
      r_op_sel   <= 4'd0;
      r_data_o   <= 32'd0;
      r_oob      <= 1'b0;
    end else begin
      r_req <= w_cap & (wr_en | r_en);
      if (w_cap && (wr_en || r_en)) begin
        r_req_wr   <= wr_en;
        r_req_addr <= addr;
        r_req_data <= data_i;
        r_req_sel  <= select;
      end
      if (w_accept) begin
        r_op_wr   <= r_req_wr;
        r_op_addr <= r_req_addr;
        r_op_data <= r_req_data;
        r_op_sel  <= r_req_sel;
        r_lat_cnt <= 4'(LATENCY - 1);
      end else if (r_state == BUSY && r_lat_cnt != 4'd0) begin
        r_lat_cnt <= r_lat_cnt - 4'd1;
      end
      if (w_done && !r_op_wr)
        r_data_o <= w_oob ? 32'hDEAD_BEEF : mem[w_idx];
      if (w_done && w_oob)
        r_oob <= 1'b1;
    end
  end

  // Memory is deliberately not reset; a reset during BUSY forces IDLE so the write never lands.
  always_ff @(posedge clk) begin
    if (w_done && r_op_wr && !w_oob) begin
      for (int b = 0; b < 4; b++)
        if (r_op_sel[b]) mem[w_idx][8*b +: 8] <= r_op_data[8*b +: 8];
    end
  end

  assign busy_o  = (r_state == BUSY);
  assign data_o  = r_data_o;
  assign oob_err = r_oob;

endmodule

// File: tb/tb_t05_sram_bus_responder.sv
// Directed bench for t05_sram_bus_responder at default parameters (LATENCY = 2, DEPTH_WORDS = 4096).
module tb_t05_sram_bus_responder;

  logic        clk = 1'b0;
  logic        nrst;
  logic        wr_en, r_en;
  logic [3:0]  select;
  logic [31:0] addr, data_i;
  logic        busy_o;
  logic [31:0] data_o;
  logic        oob_err;

  int ntests = 0;
  int nfail  = 0;

  t05_sram_bus_responder dut (
    .clk(clk), .nrst(nrst), .wr_en(wr_en), .r_en(r_en), .select(select),
    .addr(addr), .data_i(data_i), .busy_o(busy_o), .data_o(data_o), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request pulse, then checks busy_o is low, high, high, low on the following edges.
  task automatic access(input string tag, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = wr; r_en = rd; addr = a; data_i = d; select = s;
    step();
    wr_en = 1'b0; r_en = 1'b0;
    chk({tag, "_busy0"}, 32'(busy_o), 32'd0);
    step();
    chk({tag, "_busy1"}, 32'(busy_o), 32'd1);
    step();
    chk({tag, "_busy2"}, 32'(busy_o), 32'd1);
    step();
    chk({tag, "_busy3"}, 32'(busy_o), 32'd0);
  endtask

  logic [31:0] exp_low, exp_hi;
  logic        exp_oob;
  int          falls;
  logic        prev_busy;

  initial begin
    nrst = 1'b0; wr_en = 1'b0; r_en = 1'b0; select = 4'h0; addr = 32'd0; data_i = 32'd0;
    step(); step();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_oob", 32'(oob_err), 32'd0);
    nrst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_outs", {busy_o, oob_err, 30'd0} | data_o, 32'd0);
    end

    access("wr10", 1'b1, 1'b0, 32'h3300_0010, 32'hCAFE_F00D, 4'hF);
    chk("wr10_data_hold", data_o, 32'd0);
    access("rd10", 1'b0, 1'b1, 32'h3300_0010, 32'h0, 4'h0);
    chk("rd10_data", data_o, 32'hCAFE_F00D);

    access("wr20a", 1'b1, 1'b0, 32'h3300_0020, 32'h1122_3344, 4'hF);
    access("wr20b", 1'b1, 1'b0, 32'h3300_0020, 32'hAABB_CCDD, 4'b0101);
    access("rd20", 1'b0, 1'b1, 32'h3300_0020, 32'h0, 4'hF);
    chk("byte_en_data", data_o, 32'h11BB_33DD);

    access("wrrd00", 1'b1, 1'b1, 32'h3300_0000, 32'h0000_0005, 4'hF);
    chk("both_is_write", data_o, 32'h11BB_33DD);
    access("rd00", 1'b0, 1'b1, 32'h3300_0000, 32'h0, 4'h0);
    chk("both_wrote", data_o, 32'h0000_0005);

    access("wr_sel0", 1'b1, 1'b0, 32'h3300_0010, 32'h0, 4'h0);
    access("rd_sel0", 1'b0, 1'b1, 32'h3300_0010, 32'h0, 4'hF);
    chk("sel0_noop", data_o, 32'hCAFE_F00D);

    // Read held for 10 cycles: expect three completions within that window.
    r_en = 1'b1; addr = 32'h3300_0010; select = 4'h0;
    falls = 0; prev_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (prev_busy && !busy_o) falls++;
      prev_busy = busy_o;
    end
    r_en = 1'b0;
    chk("held_falls", 32'(falls), 32'd3);
    for (int i = 0; i < 5; i++) step();
    chk("held_idle", 32'(busy_o), 32'd0);
    chk("held_data", data_o, 32'hCAFE_F00D);

    access("wr30", 1'b1, 1'b0, 32'h3300_0030, 32'h0000_0007, 4'hF);
    wr_en = 1'b1; addr = 32'h3300_0030; data_i = 32'h0000_0001; select = 4'hF;
    step();
    wr_en = 1'b0;
    step();
    chk("abort_busy_1st", 32'(busy_o), 32'd1);
    step();
    chk("abort_busy_2nd", 32'(busy_o), 32'd1);
    nrst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_data", data_o, 32'd0);
    step();
    nrst = 1'b1;
    step();
    access("rd30", 1'b0, 1'b1, 32'h3300_0030, 32'h0, 4'h0);
    chk("abort_no_write", data_o, 32'h0000_0007);

`ifdef T05_SRAM_RESP_OOB_EN
    exp_low = 32'hDEAD_BEEF; exp_hi = 32'hDEAD_BEEF; exp_oob = 1'b1;
`else
    exp_low = 32'h0000_A5A5; exp_hi = 32'h0000_0005; exp_oob = 1'b0;
`endif
    access("wr_top", 1'b1, 1'b0, 32'h3300_3FFC, 32'h0000_A5A5, 4'hF);
    chk("top_oob", 32'(oob_err), 32'd0);
    access("rd_below", 1'b0, 1'b1, 32'h32FF_FFFC, 32'h0, 4'h0);
    chk("below_base_data", data_o, exp_low);
    chk("below_base_oob", 32'(oob_err), 32'(exp_oob));
    access("rd_4000", 1'b0, 1'b1, 32'h3300_4000, 32'h0, 4'h0);
    chk("oow_data", data_o, exp_hi);
    chk("oow_oob", 32'(oob_err), 32'(exp_oob));
    step(); step();
    chk("oob_sticky", 32'(oob_err), 32'(exp_oob));
    nrst = 1'b0;
    #1;
    chk("oob_cleared", 32'(oob_err), 32'd0);
    step();
    nrst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
